// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares the single unified memory port between the
// fetch stage and the load/store queue, one access at a time.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight; arbitrate and grant one requester
// ISSUE | drive the one-cycle memory strobe from the latched request
// WAIT  | count down the memory latency, capture read data at the end
// RESP  | pulse the owner's rvalid with the captured data
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_rw,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_id,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic [3:0]  ls_id_out,
    output logic        stall_out,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [3:0] LAT_W    = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_W = 4'(STARVE_MAX);

    logic [1:0]  state_q;
    logic        owner_ls_q;
    logic        rw_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  id_q;
    logic [3:0]  wait_cnt_q;
    logic [3:0]  starve_cnt_q;
    logic [31:0] if_rdata_q;
    logic [31:0] ls_rdata_q;
    logic [3:0]  ls_id_out_q;

    logic idle;
    logic grant_ls;
    logic grant_if;
    logic wait_done;

    // Arbitration: LS wins unless fetch has been starved for STARVE_MAX grants.
    always_comb begin
        idle      = (state_q == S_IDLE);
        grant_ls  = idle & ls_req & (~if_req | (starve_cnt_q != STARVE_W));
        grant_if  = idle & if_req & ~grant_ls;
        // The counter is loaded at grant so it reads 1 in the last WAIT cycle.
        wait_done = (wait_cnt_q <= 4'd1);
    end

    // Sequencer state, latency counter and latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_ls_q <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            id_q       <= '0;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_ls | grant_if) begin
                        state_q    <= S_ISSUE;
                        owner_ls_q <= grant_ls;
                        rw_q       <= grant_ls & ls_rw;
                        addr_q     <= grant_ls ? ls_addr : if_addr;
                        wdata_q    <= grant_ls ? ls_wdata : 32'd0;
                        id_q       <= grant_ls ? ls_id : 4'd0;
                        wait_cnt_q <= LAT_W;
                    end
                end
                S_ISSUE: begin
                    state_q    <= S_WAIT;
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                end
                S_WAIT: begin
                    if (wait_done) begin
                        state_q <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Response registers: captured at the end of WAIT, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            ls_id_out_q <= '0;
        end else if ((state_q == S_WAIT) && wait_done) begin
            if (owner_ls_q) begin
                ls_rdata_q  <= rw_q ? 32'd0 : mem_rdata;
                ls_id_out_q <= id_q;
            end else begin
                if_rdata_q <= mem_rdata;
            end
        end
    end

    // Starvation counter: LS grants while fetch waits, cleared by a fetch grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else if (grant_if) begin
            starve_cnt_q <= '0;
        end else if (grant_ls && if_req && (starve_cnt_q != STARVE_W)) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
        end
    end

    // Output decode; memory fields are zeroed outside the strobe cycle.
    always_comb begin
        if_gnt    = grant_if;
        ls_gnt    = grant_ls;
        stall_out = ls_req & ~grant_ls;
        mem_en    = (state_q == S_ISSUE);
        mem_rw    = mem_en & rw_q;
        mem_addr  = mem_en ? addr_q : 32'd0;
        mem_wdata = mem_en ? wdata_q : 32'd0;
        if_rvalid = (state_q == S_RESP) & ~owner_ls_q;
        ls_rvalid = (state_q == S_RESP) & owner_ls_q;
        if_rdata  = if_rdata_q;
        ls_rdata  = ls_rdata_q;
        ls_id_out = ls_id_out_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed steps followed by randomized requests,
// checked against a transaction-level model of arbitration and memory contents.
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_rw = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_id = '0;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic [3:0]  ls_id_out;
    logic        stall_out;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_id(ls_id), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .ls_id_out(ls_id_out), .stall_out(stall_out),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          starve_m = 0;
    logic [31:0] ref_mem [64];
    logic [31:0] phys_mem [64];
    logic [31:0] last_if_rdata = '0;
    logic [31:0] last_ls_rdata = '0;
    logic [3:0]  last_ls_id = '0;

    // Memory: data is presented only in the cycle the arbiter must capture it.
    logic [5:0]  r_idx;
    logic        r_wr;
    logic [31:0] r_data;
    always begin
        @(negedge clk);
        if (rst_n && mem_en) begin
            r_idx = mem_addr[7:2];
            r_wr  = mem_rw;
            if (r_wr) phys_mem[r_idx] = mem_wdata;
            r_data = phys_mem[r_idx];
            @(posedge clk);
            #1 mem_rdata = r_wr ? $urandom : r_data;
            @(posedge clk);
            #1 mem_rdata = $urandom;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_ls_fields();
        ls_rw    = 1'($urandom_range(0, 1));
        ls_addr  = $urandom & 32'hFFFF_FFFC;
        ls_wdata = $urandom;
        ls_id    = 4'($urandom_range(0, 15));
    endtask

    function automatic logic pick_ls();
        return ls_req && (!if_req || starve_m != STARVE_MAX);
    endfunction

    // One full transaction starting in an idle cycle with requests already driven.
    task automatic service(input logic exp_ls, input logic hold_if, input logic hold_ls,
                           input logic arm_ls);
        logic        o_rw;
        logic [31:0] o_addr, o_wd, o_data;
        logic [3:0]  o_id;
        o_rw   = exp_ls ? ls_rw : 1'b0;
        o_addr = exp_ls ? ls_addr : if_addr;
        o_wd   = exp_ls ? ls_wdata : 32'd0;
        o_id   = exp_ls ? ls_id : 4'd0;
        @(negedge clk);
        chk("if_gnt", 32'(if_gnt), 32'(!exp_ls));
        chk("ls_gnt", 32'(ls_gnt), 32'(exp_ls));
        chk("stall_at_grant", 32'(stall_out), 32'(ls_req && !exp_ls));
        if (exp_ls) begin
            if (if_req) starve_m = (starve_m + 1 > STARVE_MAX) ? STARVE_MAX : starve_m + 1;
        end else begin
            starve_m = 0;
        end
        if (o_rw) begin
            ref_mem[o_addr[7:2]] = o_wd;
            o_data = 32'd0;
        end else begin
            o_data = ref_mem[o_addr[7:2]];
        end
        @(posedge clk); #1;
        if (exp_ls) begin
            if (hold_ls) new_ls_fields(); else ls_req = 1'b0;
        end else begin
            if (hold_if) if_addr = $urandom & 32'hFFFF_FFFC; else if_req = 1'b0;
        end
        if (arm_ls) begin
            ls_req = 1'b1;
            new_ls_fields();
        end
        @(negedge clk);
        chk("mem_en_issue", 32'(mem_en), 32'd1);
        chk("mem_rw", 32'(mem_rw), 32'(o_rw));
        chk("mem_addr", mem_addr, o_addr);
        chk("mem_wdata", mem_wdata, o_wd);
        chk("busy_gnt", {30'd0, if_gnt, ls_gnt}, 32'd0);
        chk("stall_busy", 32'(stall_out), 32'(ls_req));
        chk("hold_if_rdata", if_rdata, last_if_rdata);
        chk("hold_ls_rdata", ls_rdata, last_ls_rdata);
        chk("hold_ls_id", 32'(ls_id_out), 32'(last_ls_id));
        for (int k = 0; k < MEM_LAT - 1; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("mem_en_wait", 32'(mem_en), 32'd0);
            chk("mem_addr_idle", mem_addr, 32'd0);
            chk("rvalid_wait", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
            chk("stall_wait", 32'(stall_out), 32'(ls_req));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("if_rvalid", 32'(if_rvalid), 32'(!exp_ls));
        chk("ls_rvalid", 32'(ls_rvalid), 32'(exp_ls));
        chk("mem_en_resp", 32'(mem_en), 32'd0);
        chk("stall_resp", 32'(stall_out), 32'(ls_req));
        if (exp_ls) begin
            chk("ls_rdata", ls_rdata, o_data);
            chk("ls_id_out", 32'(ls_id_out), 32'(o_id));
            last_ls_rdata = o_data;
            last_ls_id    = o_id;
        end else begin
            chk("if_rdata", if_rdata, o_data);
            last_if_rdata = o_data;
        end
        @(posedge clk); #1;
    endtask

    logic [7:0] order;

    initial begin
        for (int i = 0; i < 64; i++) begin
            ref_mem[i]  = $urandom;
            phys_mem[i] = ref_mem[i];
        end
        @(negedge clk);
        chk("rst_outputs", {if_gnt, if_rvalid, ls_gnt, ls_rvalid, stall_out, mem_en, mem_rw},
            32'd0);
        chk("rst_rdata", if_rdata | ls_rdata | mem_addr | mem_wdata, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single LS read.
        ref_mem[4] = 32'hDEADBEEF; phys_mem[4] = 32'hDEADBEEF;
        ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 32'h10; ls_id = 4'd5; ls_wdata = 32'h0;
        service(1'b1, 1'b0, 1'b0, 1'b0);
        // LS write, then read it back.
        ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h12345678; ls_id = 4'd9;
        service(1'b1, 1'b0, 1'b0, 1'b0);
        ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 32'h20; ls_id = 4'd3;
        service(1'b1, 1'b0, 1'b0, 1'b0);
        // Fetch alone.
        if_req = 1'b1; if_addr = 32'h4;
        service(1'b0, 1'b0, 1'b0, 1'b0);
        // Both held: fetch forced after three LS grants.
        order = 8'b1110_1110;
        if_req = 1'b1; if_addr = 32'h40;
        ls_req = 1'b1; new_ls_fields();
        for (int i = 0; i < 8; i++) service(order[7-i], 1'b1, 1'b1, 1'b0);
        if_req = 1'b0; ls_req = 1'b0;
        @(posedge clk); #1;
        // LS arrives while fetch is being serviced.
        if_req = 1'b1; if_addr = 32'h8;
        service(1'b0, 1'b0, 1'b0, 1'b1);
        service(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of WAIT.
        ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 32'h30; ls_id = 4'd7;
        @(negedge clk);
        chk("rst_test_gnt", 32'(ls_gnt), 32'd1);
        @(posedge clk); #1 ls_req = 1'b0;
        @(negedge clk);
        chk("rst_test_issue", 32'(mem_en), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", {if_gnt, if_rvalid, ls_gnt, ls_rvalid, stall_out, mem_en, mem_rw},
            32'd0);
        chk("rst_async_data", if_rdata | ls_rdata | mem_addr | mem_wdata, 32'd0);
        chk("rst_async_id", 32'(ls_id_out), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        starve_m = 0; last_if_rdata = '0; last_ls_rdata = '0; last_ls_id = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rvalid_after_rst", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
            @(posedge clk); #1;
        end
        if_req = 1'b1; if_addr = 32'h30;
        service(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!ls_req && $urandom_range(0, 1) == 1) begin
                ls_req = 1'b1;
                new_ls_fields();
            end
            if (!if_req && !ls_req) begin
                @(negedge clk);
                chk("idle_no_gnt", {29'd0, if_gnt, ls_gnt, stall_out}, 32'd0);
                @(posedge clk); #1;
            end else begin
                service(pick_ls(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
